// File: rtl/matmul_sched_pkg.sv
// Shared types for the matmul engine scheduler.
// Optional watchdog build: define MATMUL_SCHED_TIMEOUT_EN.
package matmul_sched_pkg;

    localparam int DEFAULT_DIM = 32;
    localparam int DEFAULT_DW  = $clog2(DEFAULT_DIM) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } sched_state_t;

    typedef struct packed {
        logic [DEFAULT_DW-1:0] m;
        logic [DEFAULT_DW-1:0] n;
        logic [DEFAULT_DW-1:0] p;
    } mm_dims_t;

endpackage

// File: rtl/matmul_sched_if.sv
// Request, engine and response bundle of the matmul scheduler.
// master = scheduler side, slave = requesters/engine/consumer side.
interface matmul_sched_if
    import matmul_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DIM  = DEFAULT_DIM
);
    localparam int DW = $clog2(DIM) + 1;
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_m;
    logic [NREQ*DW-1:0] req_n;
    logic [NREQ*DW-1:0] req_p;

    logic               mm_en;
    logic [DW-1:0]      mm_m;
    logic [DW-1:0]      mm_n;
    logic [DW-1:0]      mm_p;
    logic [SW-1:0]      mm_sel;
    logic               mm_done;

    logic               resp_valid;
    logic               resp_ready;
    logic [SW-1:0]      resp_id;
    logic               resp_err;

    modport master (
        input  req_valid, req_m, req_n, req_p,
        input  mm_done, resp_ready,
        output req_ready, mm_en, mm_m, mm_n, mm_p, mm_sel,
        output resp_valid, resp_id, resp_err
    );

    modport slave (
        output req_valid, req_m, req_n, req_p,
        output mm_done, resp_ready,
        input  req_ready, mm_en, mm_m, mm_n, mm_p, mm_sel,
        input  resp_valid, resp_id, resp_err
    );

endinterface

// File: rtl/matmul_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid after last_i,
// wrapping around; the pointer itself lives in the parent.
module matmul_sched_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         valid_i,
    input  logic [$clog2(NREQ)-1:0] last_i,
    output logic                    any_o,
    output logic [$clog2(NREQ)-1:0] grant_o
);
    localparam int SW = $clog2(NREQ);

    logic [SW-1:0] idx;

    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = SW'((int'(last_i) + i) % NREQ);
            if (!any_o && valid_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// Round-robin scheduler sharing one systolic matmul engine.
// Optional RUN watchdog and tmo_flag_o: MATMUL_SCHED_TIMEOUT_EN.
module matmul_sched
    import matmul_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DIM     = DEFAULT_DIM,
    parameter int TMO_CYC = 4 * DIM
) (
    input  logic           clk,
    input  logic           rst_n,
    matmul_sched_if.master bus,
`ifdef MATMUL_SCHED_TIMEOUT_EN
    output logic           tmo_flag_o,
`endif
    output logic           busy_o
);
    localparam int DW = $clog2(DIM) + 1;
    localparam int SW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1) begin : g_param_chk
        $error("matmul_sched: parameter out of range");
    end

    sched_state_t  state_q, state_d;
    logic [SW-1:0] last_q, last_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] m_q, m_d;
    logic [DW-1:0] n_q, n_d;
    logic [DW-1:0] p_q, p_d;
    logic          err_q, err_d;

    logic          any;
    logic [SW-1:0] grant;
    logic [DW-1:0] gm, gn, gp;
    logic          dims_bad;
    logic          tmo_hit;

    matmul_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .any_o   (any),
        .grant_o (grant)
    );

    assign gm = bus.req_m[int'(grant)*DW +: DW];
    assign gn = bus.req_n[int'(grant)*DW +: DW];
    assign gp = bus.req_p[int'(grant)*DW +: DW];

    assign dims_bad = (gm == '0) || (gn == '0) || (gp == '0)
                   || (gm > DW'(DIM)) || (gn > DW'(DIM))
                   || (gp > DW'(DIM));

`ifdef MATMUL_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          tmo_q;

    assign tmo_hit    = (cnt_q == CW'(TMO_CYC - 1));
    assign tmo_flag_o = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_q == LOAD) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == RUN && !bus.mm_done && tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        sel_d         = sel_q;
        m_d           = m_q;
        n_d           = n_q;
        p_d           = p_q;
        err_d         = err_q;
        bus.req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    bus.req_ready[grant] = 1'b1;
                    last_d  = grant;
                    sel_d   = grant;
                    m_d     = gm;
                    n_d     = gn;
                    p_d     = gp;
                    err_d   = dims_bad;
                    state_d = dims_bad ? RESP : LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                // done wins over a watchdog expiry in the same cycle
                if (bus.mm_done) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SW'(NREQ - 1);
            sel_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            m_q     <= m_d;
            n_q     <= n_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end

    assign bus.mm_en      = (state_q == RUN);
    assign bus.mm_m       = m_q;
    assign bus.mm_n       = n_q;
    assign bus.mm_p       = p_q;
    assign bus.mm_sel     = sel_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = sel_q;
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_matmul_sched.sv
// Randomized self-checking bench for matmul_sched against a
// rotation/dimension reference model; watchdog part needs the macro.
module tb_matmul_sched;
    import matmul_sched_pkg::*;

    localparam int NREQ = 4;
`ifdef MATMUL_SCHED_TIMEOUT_EN
    localparam int DIM = 8;
`else
    localparam int DIM = 32;
`endif
    localparam int DW      = $clog2(DIM) + 1;
    localparam int TMO_CYC = 4 * DIM;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
`ifdef MATMUL_SCHED_TIMEOUT_EN
    logic tmo_flag;
`endif

    always #5 clk = ~clk;

    matmul_sched_if #(.NREQ(NREQ), .DIM(DIM)) bus ();

    matmul_sched #(
        .NREQ    (NREQ),
        .DIM     (DIM),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef MATMUL_SCHED_TIMEOUT_EN
        .tmo_flag_o (tmo_flag),
`endif
        .busy_o     (busy)
    );

    // engine model: done after done_after enabled cycles (0 = never)
    int done_after = 0;
    bit done_force = 1'b0;
    int en_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else if (bus.mm_en) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
    end

    assign bus.mm_done = done_force
        | (bus.mm_en && done_after > 0 && en_cnt == done_after - 1);

    int npass = 0;
    int nchk  = 0;

    bit [NREQ-1:0] v;
    logic [DW-1:0] dm [NREQ];
    logic [DW-1:0] dn [NREQ];
    logic [DW-1:0] dp [NREQ];
    int model_last;

    function automatic int model_pick(bit [NREQ-1:0] vv, int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (vv[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit model_bad(int m, int n, int p);
        return m == 0 || n == 0 || p == 0 || m > DIM || n > DIM || p > DIM;
    endfunction

    function automatic logic [DW-1:0] rdim();
        int r;
        r = int'($urandom_range(0, 11));
        if (r == 0) return '0;
        if (r == 1) return DW'(DIM + 1);
        if (r == 2) return '1;
        return DW'($urandom_range(1, DIM));
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply();
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_m[i*DW +: DW] = dm[i];
            bus.req_n[i*DW +: DW] = dn[i];
            bus.req_p[i*DW +: DW] = dp[i];
        end
    endtask

    task automatic set_job(input int i, input int m, input int n, input int p);
        v[i]  = 1'b1;
        dm[i] = DW'(m);
        dn[i] = DW'(n);
        dp[i] = DW'(p);
    endtask

    task automatic wait_grant(output int g, output int waited);
        g = -1;
        waited = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.req_ready != '0) begin
                for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) g = k;
                break;
            end
            tick();
            waited++;
        end
    endtask

    task automatic wait_resp(input int g, input bit hold, output int en_cyc,
                             output int first_en, output int resp_c,
                             output int stray);
        en_cyc = 0;
        first_en = -1;
        resp_c = -1;
        stray = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 1 && !hold && g >= 0) begin
                v[g] = 1'b0;
                apply();
                #1;
            end
            if (bus.req_ready != '0) stray++;
            if (bus.mm_en) begin
                en_cyc++;
                if (first_en < 0) first_en = c;
            end
            if (bus.resp_valid) begin
                resp_c = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.resp_ready = 1'b1;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            dm[i] = '0; dn[i] = '0; dp[i] = '0;
        end
        apply();
        tick();
        tick();
        nchk++; if (bus.mm_en !== 1'b0) $display("FAIL reset_mm_en: got %0b want 0", bus.mm_en); else npass++;
        nchk++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid); else npass++;
        nchk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else npass++;
        nchk++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else npass++;
        nchk++; if (bus.mm_m !== '0 || bus.mm_sel !== '0 || bus.resp_err !== 1'b0)
            $display("FAIL reset_regs: got m=%0d sel=%0d err=%0b want 0", bus.mm_m, bus.mm_sel, bus.resp_err);
        else npass++;
        rst_n = 1'b1;
        model_last = NREQ - 1;
        tick();
    endtask

    task automatic test_contention();
        int g, w, en, fe, rc, st, exp_g;
        done_after = 3;
        v = '0;
        set_job(0, 4, 5, 6);
        set_job(1, 7, 8, 9);
        apply();
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_g = model_pick(v, model_last);
            wait_grant(g, w);
            nchk++; if (g !== exp_g || g !== j % 2) $display("FAIL cont_grant[%0d]: got %0d want %0d", j, g, j % 2); else npass++;
            if (j > 0) begin
                nchk++; if (w !== 1) $display("FAIL cont_regrant_delay[%0d]: got %0d want 1", j, w); else npass++;
            end
            model_last = exp_g;
            wait_resp(g, 1'b1, en, fe, rc, st);
            nchk++; if (bus.resp_id !== 2'(exp_g) || bus.resp_err !== 1'b0 || en !== 3)
                $display("FAIL cont_resp[%0d]: got id=%0d err=%0b en=%0d want id=%0d err=0 en=3", j, bus.resp_id, bus.resp_err, en, exp_g);
            else npass++;
        end
        v = '0;
        apply();
        tick();
    endtask

    task automatic test_single();
        int g, w, en, fe, rc, st;
        done_after = 10;
        v = '0;
        set_job(0, 4, 4, 4);
        apply();
        #1;
        nchk++; if (bus.req_ready !== 4'b0001) $display("FAIL single_req_ready: got %b want 0001", bus.req_ready); else npass++;
        wait_grant(g, w);
        model_last = 0;
        wait_resp(g, 1'b0, en, fe, rc, st);
        nchk++; if (fe !== 2) $display("FAIL single_first_en: got %0d want 2", fe); else npass++;
        nchk++; if (en !== 10) $display("FAIL single_en_len: got %0d want 10", en); else npass++;
        nchk++; if (rc !== 12) $display("FAIL single_resp_cycle: got %0d want 12", rc); else npass++;
        nchk++; if (bus.resp_id !== 2'd0 || bus.resp_err !== 1'b0)
            $display("FAIL single_resp: got id=%0d err=%0b want id=0 err=0", bus.resp_id, bus.resp_err);
        else npass++;
        nchk++; if (bus.mm_m !== DW'(4) || bus.mm_sel !== 2'd0)
            $display("FAIL single_dims_held: got m=%0d sel=%0d want m=4 sel=0", bus.mm_m, bus.mm_sel);
        else npass++;
        tick();
    endtask

    task automatic test_bad_dims();
        int g, w, en, fe, rc, st;
        for (int j = 0; j < 2; j++) begin
            v = '0;
            if (j == 0) set_job(1, 0, 4, 4);
            else set_job(1, 4, 4, DIM + 1);
            apply();
            #1;
            wait_grant(g, w);
            nchk++; if (g !== 1) $display("FAIL bad_grant[%0d]: got %0d want 1", j, g); else npass++;
            model_last = 1;
            wait_resp(g, 1'b0, en, fe, rc, st);
            nchk++; if (en !== 0 || rc !== 1) $display("FAIL bad_no_run[%0d]: got en=%0d resp_cyc=%0d want 0 and 1", j, en, rc); else npass++;
            nchk++; if (bus.resp_err !== 1'b1 || bus.resp_id !== 2'd1)
                $display("FAIL bad_resp[%0d]: got err=%0b id=%0d want err=1 id=1", j, bus.resp_err, bus.resp_id);
            else npass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        int g, w, en, fe, rc, st;
        int lost, idchg, stray_rdy;
        bus.resp_ready = 1'b0;
        done_after = 3;
        v = '0;
        set_job(1, 5, 6, 7);
        apply();
        #1;
        wait_grant(g, w);
        model_last = 1;
        wait_resp(g, 1'b0, en, fe, rc, st);
        set_job(0, 2, 2, 2);
        apply();
        lost = 0; idchg = 0; stray_rdy = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (bus.resp_valid !== 1'b1) lost++;
            if (bus.resp_id !== 2'd1 || bus.mm_m !== DW'(5)) idchg++;
            if (bus.req_ready !== '0) stray_rdy++;
        end
        nchk++; if (lost !== 0) $display("FAIL bp_valid_held: got %0d drops want 0", lost); else npass++;
        nchk++; if (idchg !== 0) $display("FAIL bp_id_stable: got %0d changes want 0", idchg); else npass++;
        nchk++; if (stray_rdy !== 0) $display("FAIL bp_no_accept: got %0d req_ready cycles want 0", stray_rdy); else npass++;
        bus.resp_ready = 1'b1;
        tick();
        nchk++; if (bus.resp_valid !== 1'b0) $display("FAIL bp_release: got resp_valid=%0b want 0", bus.resp_valid); else npass++;
        nchk++; if (bus.req_ready !== 4'b0001) $display("FAIL bp_next_grant: got %b want 0001", bus.req_ready); else npass++;
        wait_grant(g, w);
        model_last = 0;
        wait_resp(g, 1'b0, en, fe, rc, st);
        nchk++; if (bus.resp_id !== 2'd0 || en !== 3) $display("FAIL bp_second_job: got id=%0d en=%0d want 0 and 3", bus.resp_id, en); else npass++;
        tick();
    endtask

    task automatic test_done_outside_run();
        int g, w, en, fe, rc, st;
        v = '0;
        apply();
        done_force = 1'b1;
        tick();
        tick();
        nchk++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0)
            $display("FAIL stray_done_idle: got busy=%0b resp_valid=%0b want 0", busy, bus.resp_valid);
        else npass++;
        done_after = 4;
        set_job(2, 3, 3, 3);
        apply();
        #1;
        wait_grant(g, w);
        nchk++; if (g !== model_pick(v, model_last)) $display("FAIL stray_grant: got %0d want %0d", g, model_pick(v, model_last)); else npass++;
        model_last = 2;
        tick();
        v[2] = 1'b0;
        apply();
        nchk++; if (bus.mm_en !== 1'b0 || busy !== 1'b1 || bus.resp_valid !== 1'b0)
            $display("FAIL stray_done_load: got en=%0b busy=%0b rv=%0b want 0 1 0", bus.mm_en, busy, bus.resp_valid);
        else npass++;
        done_force = 1'b0;
        wait_resp(g, 1'b1, en, fe, rc, st);
        nchk++; if (en !== 4 || rc !== 5) $display("FAIL stray_done_run: got en=%0d resp_cyc=%0d want 4 and 5", en, rc); else npass++;
        tick();
    endtask

    task automatic test_random();
        int g, w, en, fe, rc, st, exp_g, k;
        bit bad;
        v = '0;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    dm[i] = rdim(); dn[i] = rdim(); dp[i] = rdim();
                end
            end
            k = int'($urandom_range(0, NREQ - 1));
            if ($countones(v) > 1 && $urandom_range(0, 3) == 0) v[k] = 1'b0;
            if (v == '0) begin
                v[k] = 1'b1;
                dm[k] = rdim(); dn[k] = rdim(); dp[k] = rdim();
            end
            done_after = int'($urandom_range(1, 8));
            apply();
            #1;
            exp_g = model_pick(v, model_last);
            bad = model_bad(int'(dm[exp_g]), int'(dn[exp_g]), int'(dp[exp_g]));
            wait_grant(g, w);
            nchk++; if (g !== exp_g) $display("FAIL rnd_grant[%0d]: got %0d want %0d", it, g, exp_g); else npass++;
            model_last = exp_g;
            wait_resp(g, 1'b0, en, fe, rc, st);
            nchk++; if (en !== (bad ? 0 : done_after) || rc !== (bad ? 1 : 2 + done_after))
                $display("FAIL rnd_timing[%0d]: got en=%0d resp_cyc=%0d want en=%0d", it, en, rc, bad ? 0 : done_after);
            else npass++;
            nchk++; if (bus.resp_id !== 2'(exp_g) || bus.resp_err !== bad || st !== 0)
                $display("FAIL rnd_resp[%0d]: got id=%0d err=%0b stray=%0d want id=%0d err=%0b", it, bus.resp_id, bus.resp_err, st, exp_g, bad);
            else npass++;
        end
        v = '0;
        apply();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int g, w;
        done_after = 0;
        v = '0;
        set_job(0, 4, 4, 4);
        apply();
        #1;
        wait_grant(g, w);
        tick();
        v = '0;
        apply();
        tick();
        tick();
        tick();
        nchk++; if (bus.mm_en !== 1'b1) $display("FAIL rst_run_entered: got mm_en=%0b want 1", bus.mm_en); else npass++;
        rst_n = 1'b0;
        #1;
        nchk++; if (bus.mm_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_async: got mm_en=%0b busy=%0b want 0 0", bus.mm_en, busy);
        else npass++;
        tick();
        rst_n = 1'b1;
        model_last = NREQ - 1;
        set_job(0, 4, 4, 4);
        set_job(1, 4, 4, 4);
        apply();
        #1;
        wait_grant(g, w);
        nchk++; if (g !== model_pick(v, model_last) || w !== 0)
            $display("FAIL rst_priority: got %0d after %0d want 0 after 0", g, w);
        else npass++;
        rst_n = 1'b0;
        v = '0;
        apply();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef MATMUL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int g, w, en, fe, rc, st;
        nchk++; if (tmo_flag !== 1'b0) $display("FAIL tmo_flag_init: got %0b want 0", tmo_flag); else npass++;
        done_after = 0;
        v = '0;
        set_job(0, 4, 4, 4);
        apply();
        #1;
        wait_grant(g, w);
        wait_resp(g, 1'b0, en, fe, rc, st);
        nchk++; if (en !== TMO_CYC) $display("FAIL tmo_en_len: got %0d want %0d", en, TMO_CYC); else npass++;
        nchk++; if (bus.resp_err !== 1'b1 || tmo_flag !== 1'b1)
            $display("FAIL tmo_resp: got err=%0b flag=%0b want 1 1", bus.resp_err, tmo_flag);
        else npass++;
        tick();
        tick();
        nchk++; if (tmo_flag !== 1'b1 || busy !== 1'b0)
            $display("FAIL tmo_sticky: got flag=%0b busy=%0b want 1 0", tmo_flag, busy);
        else npass++;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_bad_dims();
        test_backpressure();
        test_done_outside_run();
        test_random();
        test_reset_mid_run();
`ifdef MATMUL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/matmul_sched.md
Name: matmul_sched

Overview:
- Round-robin scheduler that shares one systolic matmul engine among NREQ requesters, such as conv-layer and FC-layer controllers.
- Accepts job descriptors (m, n, p dims) over a valid/ready handshake and validates them.
- Steers the engine's operand mux to the winning requester and holds the engine enable until the engine's done.
- Returns a per-job response (id, status) over a second valid/ready handshake.
- Sits between layer controllers and the matmul engine plus its operand-buffer mux.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DIM, 32, maximum matrix dimension supported by the engine.
- DW, $clog2(DIM)+1, width of one dimension field (derived; not overridden).
- TMO_CYC, 4*DIM, watchdog limit in RUN cycles (used only with MATMUL_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester job-request valid.
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle.
- req_m, req_n, req_p  in  NREQ*DW each  packed dims; requester i uses slice [i*DW +: DW].
- mm_en  out  1  engine enable.
- mm_m, mm_n, mm_p  out  DW each  latched dims driven to the engine.
- mm_sel  out  $clog2(NREQ)  operand-mux select (granted requester).
- mm_done  in  1  engine completion (level, combinational from the engine counter).
- resp_valid  out  1  job response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NREQ)  requester the response belongs to.
- resp_err  out  1  1 = job rejected or aborted; results invalid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr_last = NREQ-1, so requester 0 has first priority after reset.
- State IDLE:
  - If any req_valid, grant the first set bit searching from rr_last+1 with wrap-around.
  - Pulse req_ready[g] for exactly that cycle and latch that requester's dims into mm_m/n/p.
  - Set mm_sel = g and rr_last = g.
  - Dim check: if any dim == 0 or any dim > DIM, go to RESP with err = 1; otherwise go to LOAD.
- State LOAD: one cycle with mm_en = 0, letting the operand mux and the engine's layout logic settle; then go to RUN.
- State RUN:
  - mm_en = 1.
  - When mm_done = 1, deassert mm_en in the following cycle, set err = 0, and go to RESP.
  - mm_done seen in the same cycle as RUN entry is legal and is honoured.
- State RESP:
  - resp_valid = 1, with resp_id and resp_err held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
  - mm_m/n/p and mm_sel stay held so the consumer can read engine outputs during RESP.
- Latency:
  - Accept to first mm_en is 2 cycles.
  - mm_done to resp_valid is 1 cycle.
  - A new grant is possible in the cycle after the response handshake.
- No request is accepted outside IDLE; req_ready stays 0 and requesters hold valid.
- req_valid dropping before grant is allowed; the requester is simply not considered.
- A single requester asserting continuously is granted back-to-back.
- Competing requesters alternate strictly in rotation.
- Reset asserted mid-job: immediate return to IDLE; mm_en and resp_valid drop asynchronously; the job is lost.
- mm_done outside RUN is ignored.

Optional Feature:
- Macro MATMUL_SCHED_TIMEOUT_EN.
- When defined:
  - A RUN cycle counter is cleared on LOAD.
  - If it reaches TMO_CYC without mm_done, mm_en drops and the block goes to RESP with resp_err = 1.
  - A sticky output tmo_flag goes high and is cleared only by reset.
- When undefined:
  - No counter and no tmo_flag port.
  - RUN waits indefinitely for mm_done.

Decomposition:
- Package matmul_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} sched_state_t;
  - typedef struct packed {m, n, p} mm_dims_t, each field DW bits;
  - localparam DEFAULT_DIM = 32.
- One sub-module, rr_arbiter: NREQ-wide round-robin priority pick from the pointer, purely combinational, with the pointer kept in the parent.

Test Plan:
- Single job: req0 m=4 n=4 p=4; engine model raises done after 10 cycles.
  - Expected: req_ready[0] pulse, mm_en rising 2 cycles later and high exactly 10 cycles, then resp_valid with id 0 and err 0.
- Contention: req0 and req1 both held valid for 4 jobs.
  - Expected: grant order 0,1,0,1; resp_id sequence matches.
- Bad dims: req1 with m=0, then req1 with p=DIM+1.
  - Expected: no mm_en, resp_err = 1 both times, resp_id 1.
- Response backpressure: resp_ready held low 7 cycles.
  - Expected: resp_valid and id stable, no new req_ready, then return to IDLE on the handshake.
- Reset mid-RUN: assert rst_n low at RUN cycle 3.
  - Expected: mm_en = 0 and busy = 0 immediately; after release, req0 has first priority.
- Timeout build, with MATMUL_SCHED_TIMEOUT_EN defined, DIM=8, and an engine model that never raises done.
  - Expected: mm_en high exactly 32 cycles, then resp_err = 1 and tmo_flag = 1.
